// File: rtl/ext_pipe.sv
// Registered, flow-controlled width extender: extends IN_W-bit operands to OUT_W bits
// by per-transaction mode, buffers results in a 2-entry skid FIFO and counts deliveries.
module ext_pipe #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    localparam int EXT_W = OUT_W - IN_W;

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] d, input logic [1:0] m);
        logic [OUT_W-1:0] sx;
        sx = {{EXT_W{d[IN_W-1]}}, d};
        case (m)
            2'd0:    extend = {{EXT_W{1'b0}}, d};
            2'd1:    extend = sx;
            2'd2:    extend = ~sx + OUT_W'(1);
            2'd3:    extend = {{EXT_W{1'b1}}, d};
            default: extend = {OUT_W{1'b0}};
        endcase
    endfunction

    logic [1:0]       occ_q, occ_d;
    logic [OUT_W-1:0] head_q, head_d;
    logic [OUT_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             push_s, pop_s;
    logic [OUT_W-1:0] res_s;

    assign in_ready  = !full_q && !Clear;
    assign out_valid = valid_q;
    assign out_data  = head_q;
    assign count     = cnt_q;

    assign push_s = in_valid && in_ready;
    assign pop_s  = valid_q && out_ready;
    assign res_s  = extend(in_data, in_mode);

    // Next-state for the FIFO; the head register doubles as the output register
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (pop_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        case ({push_s, pop_s})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = res_s;
                    occ_d  = 2'd1;
                end else begin
                    tail_d = res_s;
                    occ_d  = 2'd2;
                end
            end
            2'b01: begin
                // Popping the last entry leaves head untouched so out_data keeps the last result
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end else begin
                    occ_d  = 2'd0;
                end
            end
            2'b11: begin
                head_d = res_s;
                occ_d  = occ_q;
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
        valid_d = (occ_d != 2'd0);
        full_d  = (occ_d == 2'd2);
    end

    // State registers with asynchronous clear
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            occ_q   <= 2'd0;
            head_q  <= {OUT_W{1'b0}};
            tail_q  <= {OUT_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: table-driven mode sweep, hand-written flow-control/clear sequences,
// and a randomized scoreboard run on a wider instance.
module tb_ext_pipe;

    logic clk;
    logic clear;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0] a_in_data, a_in_mode;
    logic [7:0] a_out_data, a_count;

    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_data;
    logic [1:0] b_count;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [4:0]  c_in_data;
    logic [1:0]  c_in_mode;
    logic [11:0] c_out_data;
    logic [7:0]  c_count;

    int n_cmp;
    int n_fail;

    ext_pipe #(.IN_W(2), .OUT_W(8), .CNT_W(8)) u_a (
        .Clk(clk), .Clear(clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_mode(a_in_mode), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .count(a_count));

    ext_pipe #(.IN_W(2), .OUT_W(8), .CNT_W(2)) u_b (
        .Clk(clk), .Clear(clear), .in_valid(a_in_valid), .in_ready(b_in_ready),
        .in_data(a_in_data), .in_mode(a_in_mode), .out_valid(b_out_valid),
        .out_ready(a_out_ready), .out_data(b_out_data), .count(b_count));

    ext_pipe #(.IN_W(5), .OUT_W(12), .CNT_W(8)) u_c (
        .Clk(clk), .Clear(clear), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_mode(c_in_mode), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .count(c_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic int ref_ext(input int d, input int m, input int iw, input int ow);
        int sv;
        int r;
        sv = (d >= (1 << (iw - 1))) ? d - (1 << iw) : d;
        case (m)
            0:       r = d;
            1:       r = sv;
            2:       r = -sv;
            default: r = (1 << ow) - (1 << iw) + d;
        endcase
        return r & ((1 << ow) - 1);
    endfunction

    // Scoreboard for instance A (and count of B, which sees the same traffic)
    logic [7:0] qa[$];
    int         exp_cnt_a;
    int         n_out_a;
    bit         hold_a;
    logic [7:0] hold_data_a;

    always @(negedge clk) begin
        if (clear) begin
            qa.delete();
            exp_cnt_a = 0;
            hold_a    = 1'b0;
        end else begin
            check("count_a", 64'(a_count), 64'(exp_cnt_a[7:0]));
            check("count_b", 64'(b_count), 64'(exp_cnt_a[1:0]));
            if (hold_a) begin
                check("hold_valid_a", 64'(a_out_valid), 64'(1));
                check("hold_data_a", 64'(a_out_data), 64'(hold_data_a));
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    fail("out_a_unexpected");
                end else begin
                    check("out_a", 64'(a_out_data), 64'(qa.pop_front()));
                end
                exp_cnt_a++;
                n_out_a++;
            end
            hold_a      = a_out_valid && !a_out_ready;
            hold_data_a = a_out_data;
        end
    end

    // Scoreboard for instance C: expected value pushed at acceptance from the reference model
    logic [11:0] qc[$];
    int          exp_cnt_c;
    int          n_in_c;
    int          n_out_c;
    bit          c_acc;
    bit          hold_c;
    logic [11:0] hold_data_c;

    always @(negedge clk) begin
        if (clear) begin
            qc.delete();
            exp_cnt_c = 0;
            hold_c    = 1'b0;
            c_acc     = 1'b0;
        end else begin
            check("count_c", 64'(c_count), 64'(exp_cnt_c[7:0]));
            if (hold_c) begin
                check("hold_valid_c", 64'(c_out_valid), 64'(1));
                check("hold_data_c", 64'(c_out_data), 64'(hold_data_c));
            end
            if (c_out_valid && c_out_ready) begin
                if (qc.size() == 0) begin
                    fail("out_c_unexpected");
                end else begin
                    check("out_c", 64'(c_out_data), 64'(qc.pop_front()));
                end
                exp_cnt_c++;
                n_out_c++;
            end
            if (c_in_valid && c_in_ready) begin
                qc.push_back(12'(ref_ext(int'(c_in_data), int'(c_in_mode), 5, 12)));
                n_in_c++;
                c_acc = 1'b1;
            end else begin
                c_acc = 1'b0;
            end
            hold_c      = c_out_valid && !c_out_ready;
            hold_data_c = c_out_data;
        end
    end

    // Offer one operand from posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_a(input logic [1:0] d, input logic [1:0] m, input logic [7:0] exp,
                          output int waits);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_mode  = m;
        waits      = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (a_in_ready && !clear) begin
                qa.push_back(exp);
                @(posedge clk);
                #1;
                return;
            end
            waits++;
        end
        fail("send_a_timeout");
    endtask

    task automatic drain_a();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (qa.size() == 0 && !a_out_valid) return;
        end
        fail("drain_a_timeout");
    endtask

    task automatic do_clear();
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    typedef struct {
        logic [1:0] data;
        logic [1:0] mode;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int stalls;
        int base;
        int cyc;

        n_cmp = 0;
        n_fail = 0;
        clear = 1'b1;
        a_in_valid = 1'b0; a_in_data = 2'd0; a_in_mode = 2'd0; a_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_data = 5'd0; c_in_mode = 2'd0; c_out_ready = 1'b0;

        vecs[0] = '{2'b10, 2'd0, 8'h02};
        vecs[1] = '{2'b10, 2'd1, 8'hFE};
        vecs[2] = '{2'b10, 2'd2, 8'h02};
        vecs[3] = '{2'b10, 2'd3, 8'hFE};
        vecs[4] = '{2'b01, 2'd0, 8'h01};
        vecs[5] = '{2'b01, 2'd1, 8'h01};
        vecs[6] = '{2'b01, 2'd2, 8'hFF};
        vecs[7] = '{2'b01, 2'd3, 8'hFD};

        #1;
        check("rst_in_ready", 64'(a_in_ready), 64'(0));
        check("rst_out_valid", 64'(a_out_valid), 64'(0));
        check("rst_out_data", 64'(a_out_data), 64'(0));
        check("rst_count", 64'(a_count), 64'(0));
        check("rst_out_data_c", 64'(c_out_data), 64'(0));
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        check("ready_after_clear", 64'(a_in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Mode sweep
        a_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_a(vecs[i].data, vecs[i].mode, vecs[i].exp, w);
        drain_a();
        check("sweep_count", 64'(a_count), 64'(8));

        // Backpressure: two accepts fill the buffer, third is held
        do_clear();
        a_out_ready = 1'b0;
        send_a(2'd1, 2'd0, 8'h01, w);
        send_a(2'd2, 2'd0, 8'h02, w);
        a_in_valid = 1'b1;
        a_in_data  = 2'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ready_full", 64'(a_in_ready), 64'(0));
            check("valid_full", 64'(a_out_valid), 64'(1));
        end
        @(posedge clk);
        #1 a_out_ready = 1'b1;
        send_a(2'd3, 2'd0, 8'h03, w);
        check("ready_rise_delay", 64'(w), 64'(1));
        drain_a();
        check("bp_count", 64'(a_count), 64'(3));

        // Sustained push/pop at occupancy 1
        do_clear();
        a_out_ready = 1'b1;
        stalls = 0;
        base = n_out_a;
        for (int i = 0; i < 10; i++) begin
            send_a(2'(i % 4), 2'd0, 8'(i % 4), w);
            stalls += w;
        end
        check("tput_stalls", 64'(stalls), 64'(0));
        check("tput_no_bubbles", 64'(n_out_a - base), 64'(9));
        drain_a();
        check("tput_count", 64'(a_count), 64'(10));
        check("wrap_count_b", 64'(b_count), 64'(2));

        // Clear with occupancy 2 and count 7
        do_clear();
        a_out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_a(2'(i % 4), 2'd1, 8'(ref_ext(i % 4, 1, 2, 8)), w);
        drain_a();
        check("pre_clear_count", 64'(a_count), 64'(7));
        a_out_ready = 1'b0;
        send_a(2'd1, 2'd0, 8'h01, w);
        send_a(2'd2, 2'd0, 8'h02, w);
        a_in_valid = 1'b0;
        #1 clear = 1'b1;
        #1;
        check("clr_out_valid", 64'(a_out_valid), 64'(0));
        check("clr_out_data", 64'(a_out_data), 64'(0));
        check("clr_count", 64'(a_count), 64'(0));
        check("clr_in_ready", 64'(a_in_ready), 64'(0));
        check("clr_count_b", 64'(b_count), 64'(0));
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        check("clr_ready_after", 64'(a_in_ready), 64'(1));
        @(posedge clk);
        #1 a_out_ready = 1'b1;
        send_a(2'b11, 2'd1, 8'hFF, w);
        drain_a();
        check("post_clear_count", 64'(a_count), 64'(1));

        // Random traffic with stalls on the IN_W=5 / OUT_W=12 instance
        cyc = 0;
        while (n_in_c < 1000 && cyc < 20000) begin
            if (!c_in_valid || c_acc) begin
                c_in_valid = ($urandom_range(0, 3) != 0);
                c_in_data  = 5'($urandom);
                c_in_mode  = 2'($urandom);
            end
            c_out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        c_in_valid = 1'b0;
        check("rand_accepted", 64'(n_in_c), 64'(1000));
        c_out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (qc.size() == 0 && !c_out_valid) break;
        end
        check("rand_delivered", 64'(n_out_c), 64'(1000));
        check("rand_queue_empty", 64'(qc.size()), 64'(0));
        check("rand_count", 64'(c_count), 64'(1000 % 256));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
